pdm_mic_decimator: RTL and testbench

//  Front end for the badge PDM MEMS microphone. Generates the mic bit clock, samples the 1-bit
//  PDM stream and decimates it with a 3rd-order CIC filter to signed 8-bit PCM samples.

---
 rtl/pdm_pkg.sv | 29 ++
 rtl/pdm_clk_gen.sv | 49 ++++
 rtl/pdm_mic_decimator.sv | 179 +++++++++++++++++
 tb/tb_pdm_mic_decimator.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
//   Shared constants, FSM state type and CIC width helper for the PDM
//   microphone decimator.
//   Contents:
//     CIC_ORDER    number of integrator/comb stages
//     SETTLE_COUNT decimated outputs discarded after each enable
//     state_e      decimator control states
//     cic_width()  integrator/comb register width for a given log2(R)
// -----------------------------------------------------------------------------
package pdm_pkg;

  localparam int CIC_ORDER    = 3;
  localparam int SETTLE_COUNT = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_e;

  // The CIC gain is R^CIC_ORDER. The +/-1 input needs a sign bit plus a
  // magnitude bit. Sizing for that keeps +R^3, the full-scale positive result,
  // representable instead of aliasing onto -R^3.
  function automatic int cic_width(input int decim_log);
    return 2 + CIC_ORDER * decim_log;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// -----------------------------------------------------------------------------
// pdm_clk_gen
//   Divides the system clock down to the PDM bit clock. It also produces a
//   one-cycle sample strobe in the system-clock cycle whose edge drives the
//   bit clock from 0 to 1.
//   Ports:
//     i_clk      system clock
//     i_rst_n    asynchronous active-low reset
//     i_enable   0 holds the divider cleared and the bit clock low
//     o_mic_clk  PDM bit clock, 50% duty, period 2*CLK_DIV system clocks
//     o_sample   high in the cycle whose closing edge raises o_mic_clk
// -----------------------------------------------------------------------------
module pdm_clk_gen #(
  parameter int CLK_DIV = 6
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_mic_clk,
  output logic o_sample
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_div;
  logic          r_mic_clk;
  logic          w_wrap;

  assign w_wrap = (r_div == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
    end else if (!i_enable) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
    end else if (w_wrap) begin
      r_div     <= '0;
      r_mic_clk <= ~r_mic_clk;
    end else begin
      r_div     <= r_div + 1'b1;
    end
  end

  assign o_mic_clk = r_mic_clk;
  assign o_sample  = i_enable && w_wrap && !r_mic_clk;

endmodule

// File: rtl/pdm_mic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_mic_decimator
//   PDM MEMS microphone front end. It generates the bit clock, captures the
//   1-bit stream, and decimates it by R = 2^DECIM_LOG with a 3rd-order CIC
//   filter. The CIC result is scaled and saturated to signed 8-bit PCM.
//   Ports:
//     wb_clk_i       system clock
//     wb_reset_n_i   asynchronous active-low reset
//     enable_i       1 = running, 0 = stopped and cleared (synchronous)
//     mic_clk_o      PDM bit clock to the microphone
//     mic_data_i     PDM data from the microphone
//     audio_o        signed PCM sample, held between updates
//     audio_valid_o  one-cycle strobe when audio_o updates
// -----------------------------------------------------------------------------
module pdm_mic_decimator
  import pdm_pkg::*;
#(
  parameter int CLK_DIV   = 6,
  parameter int DECIM_LOG = 6
) (
  input  logic       wb_clk_i,
  input  logic       wb_reset_n_i,
  input  logic       enable_i,
  output logic       mic_clk_o,
  input  logic       mic_data_i,
  output logic [7:0] audio_o,
  output logic       audio_valid_o
);

  localparam int W      = cic_width(DECIM_LOG);
  localparam int SHIFT  = CIC_ORDER * DECIM_LOG - 7;
  localparam int RSH    = (SHIFT > 0) ? SHIFT : 0;
  localparam int LSH    = (SHIFT < 0) ? -SHIFT : 0;
  localparam int SCNT_W = $clog2(SETTLE_COUNT + 1);

  localparam logic signed [W:0] SAT_MAX = (W + 1)'(127);
  localparam logic signed [W:0] SAT_MIN = -(W + 1)'(128);

  // Arithmetic scale by 2^-SHIFT (floor), then clip to the 8-bit PCM range.
  function automatic logic [7:0] scale_sat(input logic signed [W-1:0] v);
    logic signed [W:0] s;
    s = ($signed({v[W-1], v}) >>> RSH) <<< LSH;
    if (s > SAT_MAX)      return 8'h7F;
    else if (s < SAT_MIN) return 8'h80;
    else                  return s[7:0];
  endfunction

  logic                  w_sample;
  logic                  r_bit_p0;
  logic                  r_bit_vld_p0;
  logic signed [W-1:0]   w_x;
  logic signed [W-1:0]   w_int1;
  logic signed [W-1:0]   w_int2;
  logic signed [W-1:0]   w_int3;
  logic signed [W-1:0]   r_int1_p1;
  logic signed [W-1:0]   r_int2_p1;
  logic signed [W-1:0]   r_int3_p1;
  logic [DECIM_LOG-1:0]  r_dec_cnt_p1;
  logic                  r_dec_vld_p1;
  logic signed [W-1:0]   w_comb1;
  logic signed [W-1:0]   w_comb2;
  logic signed [W-1:0]   w_comb3;
  logic signed [W-1:0]   r_dly1_p2;
  logic signed [W-1:0]   r_dly2_p2;
  logic signed [W-1:0]   r_dly3_p2;
  logic [7:0]            r_audio_p2;
  logic                  r_vld_p2;
  state_e                r_state;
  state_e                w_state_nxt;
  logic [SCNT_W-1:0]     r_settle_cnt;
  logic                  w_emit;
  logic                  w_settle_step;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_reset_n_i),
    .i_enable  (enable_i),
    .o_mic_clk (mic_clk_o),
    .o_sample  (w_sample)
  );

  // Bit 1 maps to +1 and bit 0 maps to -1. The integrators form an unpipelined
  // cascade, so all three see the same bit in the same cycle.
  assign w_x    = r_bit_p0 ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
  assign w_int1 = r_int1_p1 + w_x;
  assign w_int2 = r_int2_p1 + w_int1;
  assign w_int3 = r_int3_p1 + w_int2;

  assign w_comb1 = r_int3_p1 - r_dly1_p2;
  assign w_comb2 = w_comb1   - r_dly2_p2;
  assign w_comb3 = w_comb2   - r_dly3_p2;

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) r_state <= IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = SETTLE;
        SETTLE:  if (r_dec_vld_p1 && r_settle_cnt == SCNT_W'(SETTLE_COUNT - 1))
                   w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_emit        = (r_state == RUN)    && r_dec_vld_p1;
    w_settle_step = (r_state == SETTLE) && r_dec_vld_p1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      r_bit_p0     <= 1'b0;
      r_bit_vld_p0 <= 1'b0;
      r_int1_p1    <= '0;
      r_int2_p1    <= '0;
      r_int3_p1    <= '0;
      r_dec_cnt_p1 <= '0;
      r_dec_vld_p1 <= 1'b0;
      r_dly1_p2    <= '0;
      r_dly2_p2    <= '0;
      r_dly3_p2    <= '0;
      r_audio_p2   <= 8'h00;
      r_vld_p2     <= 1'b0;
      r_settle_cnt <= '0;
    end else if (!enable_i) begin
      r_bit_p0     <= 1'b0;
      r_bit_vld_p0 <= 1'b0;
      r_int1_p1    <= '0;
      r_int2_p1    <= '0;
      r_int3_p1    <= '0;
      r_dec_cnt_p1 <= '0;
      r_dec_vld_p1 <= 1'b0;
      r_dly1_p2    <= '0;
      r_dly2_p2    <= '0;
      r_dly3_p2    <= '0;
      r_audio_p2   <= 8'h00;
      r_vld_p2     <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      // p0: capture the PDM bit on the bit-clock rising edge
      r_bit_vld_p0 <= w_sample;
      if (w_sample) r_bit_p0 <= mic_data_i;

      // p1: integrate once per bit, and flag the last bit of each window
      r_dec_vld_p1 <= 1'b0;
      if (r_bit_vld_p0) begin
        r_int1_p1    <= w_int1;
        r_int2_p1    <= w_int2;
        r_int3_p1    <= w_int3;
        r_dec_cnt_p1 <= r_dec_cnt_p1 + 1'b1;
        r_dec_vld_p1 <= (r_dec_cnt_p1 == {DECIM_LOG{1'b1}});
      end

      // p2: comb, scale and register the PCM sample
      r_vld_p2 <= w_emit;
      if (r_dec_vld_p1) begin
        r_dly1_p2 <= r_int3_p1;
        r_dly2_p2 <= w_comb1;
        r_dly3_p2 <= w_comb2;
      end
      if (w_emit)        r_audio_p2   <= scale_sat(w_comb3);
      if (w_settle_step) r_settle_cnt <= r_settle_cnt + 1'b1;
    end
  end

  assign audio_o       = r_audio_p2;
  assign audio_valid_o = r_vld_p2;

endmodule

// File: tb/tb_pdm_mic_decimator.sv
module tb_pdm_mic_decimator;

  localparam int CLK_DIV   = 6;
  localparam int DECIM_LOG = 6;
  localparam int R         = 1 << DECIM_LOG;
  localparam int SHIFT     = 3 * DECIM_LOG - 7;
  localparam int NSET      = 3;
  localparam int OUT_PER   = R * 2 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mic_data = 1'b0;
  logic       mic_clk;
  logic [7:0] audio;
  logic       vld;

  always #5 clk = ~clk;

  pdm_mic_decimator #(
    .CLK_DIV   (CLK_DIV),
    .DECIM_LOG (DECIM_LOG)
  ) dut (
    .wb_clk_i      (clk),
    .wb_reset_n_i  (rst_n),
    .enable_i      (en),
    .mic_clk_o     (mic_clk),
    .mic_data_i    (mic_data),
    .audio_o       (audio),
    .audio_valid_o (vld)
  );

  int checks = 0;
  int failures = 0;

  // Impulse response of the order-3 CIC: three length-R boxcars convolved together.
  longint h2 [0:2*R-2];
  longint h  [0:3*R-3];

  int         mode = 0;
  int         dens = 50;
  int         hist[$];
  logic [7:0] exp_q[$];
  bit         drv_on = 1'b0;
  int         cyc = 0;
  int         last_vld = -1;
  int         sess_vld = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int next_bit(input int idx);
    case (mode)
      1:       return 1;
      2:       return 0;
      3:       return (idx % 2 == 0) ? 1 : 0;
      4:       return (idx % 4 != 3) ? 1 : 0;
      default: return ($urandom_range(99, 0) < dens) ? 1 : 0;
    endcase
  endfunction

  // Exact filter output after n bits, from the impulse response. Bits before
  // the stream starts count as zero, which matches filter state cleared to zero.
  function automatic logic [7:0] model_out(input int n);
    longint acc = 0;
    for (int j = 0; j < 3 * R - 2; j++) begin
      int idx = n - 1 - j;
      if (idx >= 0) acc += (hist[idx] != 0) ? h[j] : -h[j];
    end
    acc = acc >>> SHIFT;
    if (acc > 127)  return 8'h7F;
    if (acc < -128) return 8'h80;
    return acc[7:0];
  endfunction

  task automatic drive_next();
    int b;
    b = next_bit(hist.size());
    mic_data = b[0];
    hist.push_back(b);
    if (hist.size() % R == 0 && hist.size() / R - 1 >= NSET)
      exp_q.push_back(model_out(hist.size()));
  endtask

  // The DUT captures on the rising edge of mic_clk, so new data is presented on the falling edge.
  always @(negedge mic_clk) if (drv_on) drive_next();

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (vld === 1'b1) begin
      sess_vld++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got audio=%0d expected no valid (t=%0t)", audio, $time);
      end else begin
        e = exp_q.pop_front();
        check("audio", audio, e);
      end
      if (last_vld >= 0) check("valid_period", cyc - last_vld, OUT_PER);
      last_vld = cyc;
    end
  end

  task automatic clear_model(input int m);
    mode = m;
    dens = $urandom_range(100, 0);
    hist.delete();
    exp_q.delete();
    sess_vld = 0;
    last_vld = -1;
  endtask

  task automatic start_session(input int m);
    @(negedge clk);
    clear_model(m);
    drive_next();
    drv_on = 1'b1;
    en = 1'b1;
  endtask

  task automatic stop_session(input string tag);
    check({tag, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    drv_on = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_off_audio"}, audio, 0);
    check({tag, "_off_valid"}, vld, 0);
    check({tag, "_off_micclk"}, mic_clk, 0);
  endtask

  task automatic wait_outputs(input int n);
    int b = (n + NSET + 1) * OUT_PER + 100;
    while (sess_vld < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("outputs_reached", (sess_vld >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_window_pos(input int pos, input int min_bits);
    int b = 4 * OUT_PER;
    while (!(hist.size() % R == pos && hist.size() >= min_bits) && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("window_pos_reached", (b > 0) ? 1 : 0, 1);
  endtask

  initial begin
    int cnt;
    int hi_cnt;

    for (int i = 0; i < 2 * R - 1; i++) h2[i] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++) h2[a + b] += 1;
    for (int i = 0; i < 3 * R - 2; i++) h[i] = 0;
    for (int a = 0; a < 2 * R - 1; a++)
      for (int b = 0; b < R; b++) h[a + b] += h2[a];

    repeat (3) @(negedge clk);
    check("rst_audio", audio, 0);
    check("rst_valid", vld, 0);
    check("rst_micclk", mic_clk, 0);
    rst_n = 1'b1;

    hi_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mic_clk !== 1'b0 || vld !== 1'b0) hi_cnt++;
    end
    check("idle_quiet", hi_cnt, 0);

    // Constant ones: bit-clock shape, settle, latency, clipped full scale.
    start_session(1);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (mic_clk !== 1'b1 && cnt < 50);
    check("micclk_first_rise", cnt, CLK_DIV);
    cnt = 0;
    while (mic_clk === 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    check("micclk_high", cnt, CLK_DIV);
    hi_cnt = cnt;
    cnt = 0;
    while (mic_clk === 1'b0 && cnt < 50) begin @(negedge clk); cnt++; end
    check("micclk_low", cnt, CLK_DIV);
    check("micclk_period", hi_cnt + cnt, 2 * CLK_DIV);

    wait_window_pos(8, NSET * R + 8);
    check("settle_no_valid", sess_vld, 0);
    check("settle_audio_zero", audio, 0);

    wait_window_pos(0, (NSET + 1) * R);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (mic_clk !== 1'b1 && cnt < 50);
    check("lat_capture_seen", mic_clk, 1);
    check("lat_c0", vld, 0);
    @(negedge clk); check("lat_c1", vld, 0);
    @(negedge clk); check("lat_c2", vld, 1);
    @(negedge clk); check("lat_c3", vld, 0);

    wait_outputs(4);
    check("const1_level", audio, 8'h7F);
    stop_session("ones");

    start_session(2);
    wait_outputs(3);
    check("const0_level", audio, 8'h80);
    stop_session("zeros");

    start_session(3);
    wait_outputs(3);
    check("p1010_level", audio, 8'h00);
    stop_session("p1010");

    start_session(4);
    wait_outputs(3);
    check("p1110_level", audio, 8'h40);
    stop_session("p1110");

    // Random density, dropped mid-window.
    start_session(0);
    wait_outputs(5);
    wait_window_pos(25, 0);
    stop_session("rnd_disable");
    repeat (10) @(negedge clk);
    check("idle_micclk_after_disable", mic_clk, 0);

    // Re-enable; reset pulsed mid-window.
    start_session(0);
    wait_outputs(3);
    wait_window_pos(30, 0);
    @(negedge clk);
    drv_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstpulse_audio", audio, 0);
    check("rstpulse_valid", vld, 0);
    check("rstpulse_micclk", mic_clk, 0);
    repeat (2) @(negedge clk);
    clear_model(0);
    drive_next();
    drv_on = 1'b1;
    rst_n = 1'b1;
    wait_outputs(3);
    stop_session("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
